// File: rtl/atx_pll_reconfig_master_pkg.sv
`default_nettype none
// ============================================================================
// Module : atx_pll_reconfig_master_pkg
// Brief  : Shared types and defaults for the ATX PLL reconfiguration master:
//          command op encoding, FSM state encoding, bus width defaults.
// Rev    : 1.0  initial release
// ============================================================================
package atx_pll_reconfig_master_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_RMW     = 2'b10,
    OP_RMW_CAL = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR       = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_CAL_WAIT = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  // States that share the timeout counter
  function automatic logic is_timed(input state_t s);
    return (s == ST_RD) || (s == ST_WR) || (s == ST_CAL_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/atx_pll_reconfig_master_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module : reconfig_timeout_ctr
// Brief  : Saturating wait counter. Cleared on entry to a waiting state,
//          counts every enabled cycle, flags expired once it reaches TIMEOUT.
// Rev    : 1.0  initial release
// ============================================================================
module reconfig_timeout_ctr #(
  parameter int TIMEOUT = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Count up while enabled, holding at the limit so expired stays asserted
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/atx_pll_reconfig_master.sv
`default_nettype none
// ============================================================================
// Module : atx_pll_reconfig_master
// Brief  : Command-driven Avalon-MM master for ATX PLL reconfiguration.
//          Executes READ, WRITE, read-modify-write and RMW followed by a
//          calibration wait, with a per-access timeout and sticky error.
// Rev    : 1.0  initial release
// ============================================================================
module atx_pll_reconfig_master
  import atx_pll_reconfig_master_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = 4095,
  parameter int CAL_SETTLE = 16
) (
  input  logic              reconfig_clk,
  input  logic              reconfig_reset,
  // command / response
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  // Avalon-MM reconfiguration bus
  output logic              reconfig_write,
  output logic              reconfig_read,
  output logic [ADDR_W-1:0] reconfig_address,
  output logic [DATA_W-1:0] reconfig_writedata,
  input  logic [DATA_W-1:0] reconfig_readdata,
  input  logic              reconfig_waitrequest,
  // calibration status
  input  logic              pll_cal_busy
);

  localparam int SETTLE_W = (CAL_SETTLE > 1) ? $clog2(CAL_SETTLE) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(CAL_SETTLE - 1);

  state_t              state;
  state_t              state_next;
  op_t                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                err_set;
  logic                accept;
  logic                tmo_clear;
  logic                tmo_enable;
  logic                tmo_expired;
  logic [SETTLE_W-1:0] settle_cnt;

  assign cmd_ready = (state == ST_IDLE) && !reconfig_reset;
  assign accept    = cmd_valid && cmd_ready;

  // Shared wait counter: restarts whenever a waiting state is freshly entered
  assign tmo_clear  = (state_next != state) && is_timed(state_next);
  assign tmo_enable = is_timed(state);

  reconfig_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (reconfig_clk),
    .rst     (reconfig_reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // State register
  always_ff @(posedge reconfig_clk) begin
    if (reconfig_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command latch, read-data capture and sticky error
  always_ff @(posedge reconfig_clk) begin
    if (reconfig_reset) begin
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_t'(cmd_op);
        addr_q  <= cmd_address;
        wdata_q <= cmd_wdata;
        mask_q  <= cmd_mask;
        if (op_t'(cmd_op) == OP_WRITE) begin
          rdata_q <= '0;
        end
      end else if ((state == ST_RD) && !reconfig_waitrequest) begin
        rdata_q <= reconfig_readdata;
      end
      if (state == ST_RESP) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Settle delay after the calibration write; pll_cal_busy is not looked at
  always_ff @(posedge reconfig_clk) begin
    if (reconfig_reset || (state != ST_SETTLE)) begin
      settle_cnt <= '0;
    end else begin
      settle_cnt <= settle_cnt + SETTLE_W'(1);
    end
  end

  // Next-state and bus strobes; a ready handshake beats a same-cycle timeout
  always_comb begin
    state_next     = state;
    err_set        = 1'b0;
    reconfig_read  = 1'b0;
    reconfig_write = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = (op_t'(cmd_op) == OP_WRITE) ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        reconfig_read = 1'b1;
        if (!reconfig_waitrequest) begin
          state_next = (op_q == OP_READ) ? ST_RESP : ST_WR;
        end else if (tmo_expired) begin
          err_set    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_WR: begin
        reconfig_write = 1'b1;
        if (!reconfig_waitrequest) begin
          state_next = (op_q == OP_RMW_CAL) ? ST_SETTLE : ST_RESP;
        end else if (tmo_expired) begin
          err_set    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = ST_CAL_WAIT;
        end
      end
      ST_CAL_WAIT: begin
        if (!pll_cal_busy) begin
          state_next = ST_RESP;
        end else if (tmo_expired) begin
          err_set    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rsp_valid          = (state == ST_RESP);
  assign rsp_error          = rsp_valid && err_q;
  assign rsp_rdata          = rdata_q;
  assign reconfig_address   = addr_q;
  assign reconfig_writedata = (op_q == OP_WRITE) ? wdata_q
                                                 : ((rdata_q & ~mask_q) | (wdata_q & mask_q));

endmodule
`default_nettype wire

// File: tb/tb_atx_pll_reconfig_master.sv
`default_nettype none
// ============================================================================
// Module : tb_atx_pll_reconfig_master
// Brief  : Self-checking bench for atx_pll_reconfig_master. u_dut uses a
//          short timeout; u_cal shares the stimulus with a long timeout so a
//          long calibration wait can complete without error.
// Rev    : 1.0  initial release
// ============================================================================
module tb_atx_pll_reconfig_master;
  import atx_pll_reconfig_master_pkg::*;

  localparam int AW     = 11;
  localparam int DW     = 32;
  localparam int TMO    = 15;
  localparam int SETTLE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] cmd_mask;
  logic [DW-1:0] readdata;
  logic          waitrequest;
  logic          cal_busy;
  logic          use_cal;

  logic          d_ready, d_rsp_valid, d_err, d_rd, d_wr;
  logic [DW-1:0] d_rdata, d_wdata;
  logic [AW-1:0] d_addr;
  logic          c_ready, c_rsp_valid, c_err, c_rd, c_wr;
  logic [DW-1:0] c_rdata, c_wdata;
  logic [AW-1:0] c_addr;

  logic          sel_ready, sel_rsp_valid, sel_err, sel_rd, sel_wr;
  logic [DW-1:0] sel_rdata, sel_wdata;
  logic [AW-1:0] sel_addr;

  always #5 clk = ~clk;

  atx_pll_reconfig_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .CAL_SETTLE(SETTLE)
  ) u_dut (
    .reconfig_clk(clk), .reconfig_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(d_ready), .cmd_op(cmd_op),
    .cmd_address(cmd_address), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(d_rsp_valid), .rsp_rdata(d_rdata), .rsp_error(d_err),
    .reconfig_write(d_wr), .reconfig_read(d_rd), .reconfig_address(d_addr),
    .reconfig_writedata(d_wdata), .reconfig_readdata(readdata),
    .reconfig_waitrequest(waitrequest), .pll_cal_busy(cal_busy)
  );

  atx_pll_reconfig_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4095), .CAL_SETTLE(SETTLE)
  ) u_cal (
    .reconfig_clk(clk), .reconfig_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(c_ready), .cmd_op(cmd_op),
    .cmd_address(cmd_address), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(c_rsp_valid), .rsp_rdata(c_rdata), .rsp_error(c_err),
    .reconfig_write(c_wr), .reconfig_read(c_rd), .reconfig_address(c_addr),
    .reconfig_writedata(c_wdata), .reconfig_readdata(readdata),
    .reconfig_waitrequest(waitrequest), .pll_cal_busy(cal_busy)
  );

  assign sel_ready     = use_cal ? c_ready     : d_ready;
  assign sel_rsp_valid = use_cal ? c_rsp_valid : d_rsp_valid;
  assign sel_err       = use_cal ? c_err       : d_err;
  assign sel_rd        = use_cal ? c_rd        : d_rd;
  assign sel_wr        = use_cal ? c_wr        : d_wr;
  assign sel_rdata     = use_cal ? c_rdata     : d_rdata;
  assign sel_wdata     = use_cal ? c_wdata     : d_wdata;
  assign sel_addr      = use_cal ? c_addr      : d_addr;

  typedef struct {
    logic          use_cal;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mask;
    logic [DW-1:0] rdata;
    int            waits;
    int            busy_lo;
    int            busy_hi;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] exp_wdata;
    logic          exp_err;
    int            exp_lat;
    int            exp_rd;
    int            exp_wr;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];
  vec_t post_rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one command, act as the bus slave, compare against the scoreboard
  task automatic run_cmd(input vec_t v);
    int   cyc;
    int   rd_n;
    int   wr_n;
    int   acc_wait;
    bit   done;
    exp_t e;
    use_cal = v.use_cal;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = v.op;
    cmd_address = v.addr;
    cmd_wdata   = v.wdata;
    cmd_mask    = v.mask;
    readdata    = v.rdata;
    waitrequest = 1'b0;
    cal_busy    = 1'b0;
    acc_wait    = 0;
    while (!sel_ready && acc_wait < 20) begin
      @(negedge clk);
      acc_wait++;
    end
    chk("accept_ready", 32'(sel_ready), 32'd1);
    sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
    @(posedge clk);
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_op      = 2'($urandom);
    cmd_address = AW'($urandom);
    cmd_wdata   = $urandom;
    cmd_mask    = $urandom;
    cyc  = 1;
    rd_n = 0;
    wr_n = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      cal_busy = (cyc >= v.busy_lo) && (cyc <= v.busy_hi);
      chk("strobe_exclusive", 32'(sel_rd && sel_wr), 32'd0);
      if (sel_rd) begin
        waitrequest = (rd_n < v.waits);
        readdata    = waitrequest ? $urandom : v.rdata;
        rd_n++;
        chk("rd_addr", 32'(sel_addr), 32'(v.addr));
      end else if (sel_wr) begin
        waitrequest = (wr_n < v.waits);
        wr_n++;
        chk("wr_addr", 32'(sel_addr), 32'(v.addr));
        chk("wr_data", sel_wdata, v.exp_wdata);
      end else begin
        waitrequest = 1'b0;
      end
      if (sel_rsp_valid) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", sel_rdata, e.rdata);
          chk("rsp_error", 32'(sel_err), 32'(e.err));
          chk("latency", 32'(cyc), 32'(e.lat));
        end
      end else begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    chk("rd_cycles", 32'(rd_n), 32'(v.exp_rd));
    chk("wr_cycles", 32'(wr_n), 32'(v.exp_wr));
    cal_busy    = 1'b0;
    waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_one_cycle", 32'(sel_rsp_valid), 32'd0);
    chk("ready_after_rsp", 32'(sel_ready), 32'd1);
  endtask

  initial begin
    int acc;
    int rsp;
    int ov;
    int seen;
    exp_t e;

    // use_cal op addr wdata mask rdata waits busy_lo busy_hi | exp_rdata exp_wdata err lat rd wr
    vecs[0]  = '{1'b0, OP_READ,    11'h100, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_0001, 0,   1000, 0,
                 32'hA5A5_0001, 32'h0000_0000, 1'b0, 2,  1,  0};
    vecs[1]  = '{1'b0, OP_WRITE,   11'h055, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h1111_1111, 0,   1000, 0,
                 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 2,  0,  1};
    vecs[2]  = '{1'b0, OP_RMW,     11'h0F0, 32'h0000_0030, 32'h0000_00F0, 32'h1234_5678, 3,   1000, 0,
                 32'h1234_5678, 32'h1234_5638, 1'b0, 9,  4,  4};
    vecs[3]  = '{1'b0, OP_RMW,     11'h3A5, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0F0F_0F0F, 0,   1000, 0,
                 32'h0F0F_0F0F, 32'hAAAA_0F0F, 1'b0, 3,  1,  1};
    vecs[4]  = '{1'b0, OP_RMW_CAL, 11'h200, 32'h0000_AB00, 32'h0000_FF00, 32'h1122_3344, 0,   3,    6,
                 32'h1122_3344, 32'h1122_AB44, 1'b0, 8,  1,  1};
    vecs[5]  = '{1'b1, OP_RMW_CAL, 11'h201, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h0000_0000, 0,   1,    56,
                 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 58, 1,  1};
    vecs[6]  = '{1'b0, OP_READ,    11'h011, 32'h0000_0000, 32'h0000_0000, 32'h600D_F00D, 15,  1000, 0,
                 32'h600D_F00D, 32'h0000_0000, 1'b0, 17, 16, 0};
    vecs[7]  = '{1'b0, OP_READ,    11'h012, 32'h0000_0000, 32'h0000_0000, 32'h0BAD_BEEF, 255, 1000, 0,
                 32'h600D_F00D, 32'h0000_0000, 1'b1, 17, 16, 0};
    vecs[8]  = '{1'b0, OP_RMW,     11'h013, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0BAD_BEEF, 255, 1000, 0,
                 32'h600D_F00D, 32'h0000_0000, 1'b1, 17, 16, 0};
    vecs[9]  = '{1'b0, OP_WRITE,   11'h014, 32'h8765_4321, 32'h0000_0000, 32'h0000_0000, 255, 1000, 0,
                 32'h0000_0000, 32'h8765_4321, 1'b1, 17, 0,  16};
    vecs[10] = '{1'b0, OP_WRITE,   11'h015, 32'h1357_9BDF, 32'h0000_0000, 32'h0000_0000, 14,  1000, 0,
                 32'h0000_0000, 32'h1357_9BDF, 1'b0, 16, 0,  15};
    post_rst = '{1'b0, OP_READ,    11'h100, 32'h0000_0000, 32'h0000_0000, 32'h5A5A_1234, 0,   1000, 0,
                 32'h5A5A_1234, 32'h0000_0000, 1'b0, 2,  1,  0};

    // Reset state
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_address = '0;
    cmd_wdata = '0; cmd_mask = '0; readdata = '0; waitrequest = 1'b0;
    cal_busy = 1'b0; use_cal = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",     32'(d_ready),     32'd0);
    chk("rst_read",      32'(d_rd),        32'd0);
    chk("rst_write",     32'(d_wr),        32'd0);
    chk("rst_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(d_err),       32'd0);
    chk("rst_rdata",     d_rdata,          32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", 32'(d_ready), 32'd1);

    // Table-driven transactions
    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i]);
    end

    // Reset in the middle of an RMW write phase
    use_cal = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_RMW; cmd_address = 11'h020;
    cmd_wdata = 32'h0; cmd_mask = 32'h0; readdata = 32'h7777_7777; waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_rst_rd_phase", 32'(d_rd), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_wr_phase", 32'(d_wr), 32'd1);
    waitrequest = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_rst_wr_held", 32'(d_wr), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_wr_low",   32'(d_wr),        32'd0);
    chk("mid_rst_rd_low",   32'(d_rd),        32'd0);
    chk("mid_rst_no_rsp",   32'(d_rsp_valid), 32'd0);
    chk("mid_rst_rdata",    d_rdata,          32'd0);
    rst = 1'b0;
    waitrequest = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_rsp_valid || d_wr || d_rd) seen++;
    end
    chk("mid_rst_quiet", 32'(seen), 32'd0);
    run_cmd(post_rst);

    // cmd_valid held high: one acceptance per IDLE visit
    use_cal = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_address = 11'h0AB; waitrequest = 1'b0;
    acc = 0; rsp = 0; ov = 0;
    for (int c = 0; c < 21; c++) begin
      if (d_rd && d_wr) ov++;
      if (d_rsp_valid) begin
        rsp++;
        if (sb.size() == 0) begin
          chk("b2b_scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("b2b_rdata", d_rdata, e.rdata);
        end
      end
      if (cmd_valid && d_ready) begin
        acc++;
        readdata = 32'hB000_0000 + 32'(acc);
        sb.push_back('{32'hB000_0000 + 32'(acc), 1'b0, 0});
      end
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts",   32'(acc), 32'd7);
    chk("b2b_responses", 32'(rsp), 32'd7);
    chk("b2b_overlap",   32'(ov),  32'd0);
    chk("b2b_sb_drain",  32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atx_pll_reconfig_master.md
ATX_PLL_RECONFIG_MASTER -- requirements
Module: atx_pll_reconfig_master

Interface
REQ-001 Parameter ADDR_W, default 11: reconfig address width.
REQ-002 Parameter DATA_W, default 32: reconfig data width.
REQ-003 Parameter TIMEOUT, default 4095: maximum cycles to wait per bus access or per calibration wait.
REQ-004 Parameter CAL_SETTLE, default 16: cycles after the last write before pll_cal_busy is sampled.
REQ-005 reconfig_clk  in  1: the single clock; all logic is on its rising edge.
REQ-006 reconfig_reset  in  1: reset, synchronous and active-high.
REQ-007 cmd_valid  in  1: command request.
REQ-008 cmd_ready  out  1: command accepted when cmd_valid and cmd_ready are both high.
REQ-009 cmd_op  in  2: 00 READ, 01 WRITE, 10 RMW, 11 RMW_CAL.
REQ-010 cmd_address  in  ADDR_W: target register address.
REQ-011 cmd_wdata  in  DATA_W: write data.
REQ-012 cmd_mask  in  DATA_W: bit mask for RMW; ignored for READ/WRITE.
REQ-013 rsp_valid  out  1: one-cycle completion pulse.
REQ-014 rsp_rdata  out  DATA_W: register value read (READ and RMW ops); 0 for WRITE.
REQ-015 rsp_error  out  1: a timeout occurred; qualified by rsp_valid.
REQ-016 reconfig_write, reconfig_read  out  1 each: Avalon-MM master strobes.
REQ-017 reconfig_address  out  ADDR_W; reconfig_writedata  out  DATA_W.
REQ-018 reconfig_readdata  in  DATA_W; reconfig_waitrequest  in  1.
REQ-019 pll_cal_busy  in  1: PLL calibration in progress.

Function
REQ-020 FSM states: IDLE, RD, WR, SETTLE, CAL_WAIT, RESP.
REQ-021 cmd_ready SHALL be high only in IDLE; on acceptance, the block latches op, address, wdata and mask, and the command inputs are then ignored until the next IDLE.
REQ-022 Accept transitions: READ/RMW/RMW_CAL -> RD; WRITE -> WR.
REQ-023 RD asserts reconfig_read with a stable address until a cycle with reconfig_waitrequest=0.
  - In that cycle, reconfig_readdata is captured into rsp_rdata.
  - Then READ -> RESP; RMW/RMW_CAL -> WR.
REQ-024 WR asserts reconfig_write with stable address and data until a cycle with reconfig_waitrequest=0.
  - Write data for WRITE: cmd_wdata.
  - Write data for RMW: (rdata & ~mask) | (wdata & mask).
  - Then RMW_CAL -> SETTLE; otherwise -> RESP.
REQ-025 reconfig_read and reconfig_write SHALL never be high together, and SHALL be low outside RD/WR.
REQ-026 SETTLE counts CAL_SETTLE cycles, ignores pll_cal_busy, then goes to CAL_WAIT.
REQ-027 CAL_WAIT exits to RESP in the first cycle pll_cal_busy=0.
REQ-028 A shared counter, cleared on each entry to RD, WR or CAL_WAIT, increments every cycle in that state.
  - When it reaches TIMEOUT, the block sets a sticky error and goes to RESP.
  - In that case, strobes deassert in the same transition.
REQ-029 An error in RD of an RMW SHALL skip the write.
REQ-030 RESP asserts rsp_valid for exactly one cycle with rsp_error=sticky error, then returns to IDLE and clears the error.
REQ-031 rsp_rdata SHALL hold its value until the next read capture; WRITE ops drive it to 0 at acceptance.
REQ-032 Minimum latency, zero wait states:
  - READ: acceptance -> rsp_valid = 2 cycles.
  - RMW: 3 cycles.
  - RMW_CAL: 3 + CAL_SETTLE + 1 cycles.
REQ-033 waitrequest=0 in the same cycle the timeout is reached SHALL count as success.

Reset
REQ-034 While reconfig_reset=1, at the next edge:
  - state is IDLE.
  - cmd_ready is 0 during reset and 1 in the first cycle after.
  - All strobes, rsp_valid and rsp_error are 0.
  - rsp_rdata and the counter are 0.
REQ-035 Reset mid-transaction SHALL abort immediately, with no rsp_valid and with strobes low on the next cycle.

Structure
REQ-036 The shared package holds:
  - the op encoding (READ/WRITE/RMW/RMW_CAL);
  - the FSM state enum;
  - the ADDR_W/DATA_W defaults.
REQ-037 One sub-module, reconfig_timeout_ctr: clear/enable inputs, an expired output at TIMEOUT.

Verification
REQ-038 READ of 0x100 with zero wait states, readdata=0xA5A5_0001 -> one read strobe, rsp_valid 2 cycles after acceptance, rsp_rdata=0xA5A5_0001, rsp_error=0.
REQ-039 RMW of 0x0F0, mask=0x0000_00F0, wdata=0x0000_0030, readdata=0x1234_5678, 3 waitrequest cycles on each access -> writedata=0x1234_5638.
REQ-040 RMW_CAL with pll_cal_busy high for 50 cycles after SETTLE -> rsp_valid exactly 1 cycle after pll_cal_busy falls, rsp_error=0.
REQ-041 waitrequest stuck high on a READ, TIMEOUT=15 -> read deasserts, rsp_valid with rsp_error=1, no write issued.
REQ-042 reconfig_reset pulsed during WR -> write strobe low next cycle, no rsp_valid, a following READ completes normally.
REQ-043 cmd_valid held high back-to-back -> exactly one command accepted per IDLE visit, and bus strobes never overlap.
